uart_rx: RTL and testbench

8N1 UART receiver, the receive-side counterpart of the team's uart_tx. It recovers bytes from the asynchronous serial line (e.g. the USB-UART bridge RX pin) using the same CD_MAX clock-divider convention as uart_tx. Each byte is delivered as a one-cycle valid pulse with the data held until the next byte arrives. A bad stop bit is flagged with an error pulse instead.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, the receive-side counterpart of uart_tx.
// The serial line is synchronised, the start bit is qualified at its
// midpoint, and each data bit and the stop bit are then sampled one full bit
// period apart, landing near the centre of each bit.
module uart_rx #(
  parameter int CD_MAX   = 10416,
  parameter int CD_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rbus,
  output logic       rvalid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CD_WIDTH-1:0] CD_FULL = CD_WIDTH'(CD_MAX);
  localparam logic [CD_WIDTH-1:0] CD_HALF = CD_WIDTH'(CD_MAX / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t              state, state_n;
  logic [CD_WIDTH-1:0] cd_count, cd_count_n;
  logic [3:0]          bit_count, bit_count_n;
  logic [7:0]          shift, shift_n;
  logic [7:0]          rbus_n;
  logic                rvalid_n, frame_err_n, busy_n;
  logic                rx_meta, rx_s;

  // Two-flop synchroniser; both flops reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers; reset wins over everything, mid-frame too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cd_count  <= '0;
      bit_count <= '0;
      shift     <= '0;
      rbus      <= '0;
      rvalid    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cd_count  <= cd_count_n;
      bit_count <= bit_count_n;
      shift     <= shift_n;
      rbus      <= rbus_n;
      rvalid    <= rvalid_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
    end
  end

  // Next-state logic: bit timing, LSB-first shifting and stop-bit verdict.
  always_comb begin
    state_n     = state;
    cd_count_n  = cd_count;
    bit_count_n = bit_count;
    shift_n     = shift;
    rbus_n      = rbus;
    rvalid_n    = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      IDLE: begin
        cd_count_n  = '0;
        bit_count_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end

      START: begin
        if (cd_count == CD_HALF) begin
          cd_count_n = '0;
          state_n    = rx_s ? IDLE : DATA;
        end else begin
          cd_count_n = cd_count + CD_WIDTH'(1);
        end
      end

      DATA: begin
        if (cd_count == CD_FULL) begin
          cd_count_n = '0;
          shift_n    = {rx_s, shift[7:1]};
          if (bit_count == 4'd7) begin
            bit_count_n = '0;
            state_n     = STOP;
          end else begin
            bit_count_n = bit_count + 4'd1;
          end
        end else begin
          cd_count_n = cd_count + CD_WIDTH'(1);
        end
      end

      STOP: begin
        if (cd_count == CD_FULL) begin
          cd_count_n = '0;
          if (rx_s) begin
            rbus_n   = shift;
            rvalid_n = 1'b1;
            state_n  = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BRK;
          end
        end else begin
          cd_count_n = cd_count + CD_WIDTH'(1);
        end
      end

      BRK: begin
        cd_count_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CD_MAX=15 with a byte scoreboard.
module tb_uart_rx;

  localparam int BIT_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rbus;
  logic       rvalid;
  logic       frame_err;
  logic       busy;

  int checks      = 0;
  int passed      = 0;
  int valid_count = 0;
  int err_count   = 0;
  logic [7:0] exp_q[$];
  logic prev_rvalid = 1'b0;
  logic prev_ferr   = 1'b0;

  uart_rx #(.CD_MAX(15), .CD_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rbus(rbus),
    .rvalid(rvalid),
    .frame_err(frame_err),
    .busy(busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // One comparison: count it and report any difference
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks = checks + 1;
    assert (observed === expected) passed = passed + 1;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Hold the line at one level for one bit period, changing on the falling edge
  task automatic driveBit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (BIT_CYCLES - 1) @(negedge clk);
  endtask

  // Send one 8N1 frame LSB first; good frames are queued for the scoreboard
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input bit push);
    if (push) exp_q.push_back(data);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stop_bit);
  endtask

  // Output monitor: pulse widths, exclusivity and scoreboard pops
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      valid_count = valid_count + 1;
      checkOutput("rvalid_with_ferr", {15'd0, frame_err}, 16'd0);
      checkOutput("rvalid_width", {15'd0, prev_rvalid}, 16'd0);
      if (exp_q.size() > 0) checkOutput("rbus_scoreboard", {8'd0, rbus}, {8'd0, exp_q.pop_front()});
      else checkOutput("scoreboard_nonempty", 16'(exp_q.size()), 16'd1);
    end
    if (frame_err === 1'b1) begin
      err_count = err_count + 1;
      checkOutput("ferr_width", {15'd0, prev_ferr}, 16'd0);
    end
    prev_rvalid = rvalid;
    prev_ferr   = frame_err;
  end

  // Directed sequence
  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rbus", {8'd0, rbus}, 16'h0000);
    checkOutput("reset_rvalid", {15'd0, rvalid}, 16'd0);
    checkOutput("reset_ferr", {15'd0, frame_err}, 16'd0);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single good frame
    applyStimulus(8'h55, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("single_valid_count", 16'(valid_count), 16'd1);
    checkOutput("single_err_count", 16'(err_count), 16'd0);
    checkOutput("single_rbus", {8'd0, rbus}, 16'h0055);
    checkOutput("single_busy_after", {15'd0, busy}, 16'd0);

    // Back-to-back frames with no gap
    applyStimulus(8'hA5, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("b2b_valid_count", 16'(valid_count), 16'd4);
    checkOutput("b2b_err_count", 16'(err_count), 16'd0);
    checkOutput("b2b_rbus", {8'd0, rbus}, 16'h00FF);

    // Short low glitch is rejected at the start-bit midpoint
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("glitch_busy_during", {15'd0, busy}, 16'd1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("glitch_valid_count", 16'(valid_count), 16'd4);
    checkOutput("glitch_err_count", 16'(err_count), 16'd0);
    checkOutput("glitch_rbus", {8'd0, rbus}, 16'h00FF);
    checkOutput("glitch_busy_after", {15'd0, busy}, 16'd0);

    // Bad stop bit followed by a held-low line
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("break_err_count", 16'(err_count), 16'd1);
    checkOutput("break_valid_count", 16'(valid_count), 16'd4);
    checkOutput("break_rbus_kept", {8'd0, rbus}, 16'h00FF);
    checkOutput("break_busy_held", {15'd0, busy}, 16'd1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("break_busy_released", {15'd0, busy}, 16'd0);
    applyStimulus(8'h81, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("after_break_valid_count", 16'(valid_count), 16'd5);
    checkOutput("after_break_rbus", {8'd0, rbus}, 16'h0081);

    // Reset in the middle of data bit 4 of a 0xF0 frame
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_rbus", {8'd0, rbus}, 16'h0000);
    checkOutput("midreset_rvalid", {15'd0, rvalid}, 16'd0);
    checkOutput("midreset_ferr", {15'd0, frame_err}, 16'd0);
    checkOutput("midreset_busy", {15'd0, busy}, 16'd0);
    repeat (100) @(negedge clk);
    checkOutput("midreset_valid_count", 16'(valid_count), 16'd5);
    checkOutput("midreset_err_count", 16'(err_count), 16'd1);
    applyStimulus(8'h7E, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("post_reset_valid_count", 16'(valid_count), 16'd6);
    checkOutput("post_reset_rbus", {8'd0, rbus}, 16'h007E);
    checkOutput("final_err_count", 16'(err_count), 16'd1);

    checkOutput("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
